// File: rtl/fetch_predict.sv
// Fetch stage with 2-bit BHT branch prediction and the IF/ID register feeding decode.
// A one-entry holding buffer catches a word that returns while decode is stalled.
module fetch_predict #(
  parameter int          IDX_BITS = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        misprediction,
  input  logic [15:0] redirect_pc,
  input  logic        resolve_valid,
  input  logic [15:0] resolve_pc,
  input  logic        resolve_taken,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_err,
  output logic [15:0] instr,
  output logic [15:0] PC,
  output logic        expectedTaken,
  output logic        NOP_mech,
  output logic        IDF_err,
  output logic        valid
);

  localparam int          BHT_ENTRIES = 2 ** IDX_BITS;
  localparam logic [1:0]  S_RUN    = 2'd0;
  localparam logic [1:0]  S_WAIT   = 2'd1;
  localparam logic [1:0]  S_SQUASH = 2'd2;
  localparam logic [1:0]  S_HALT   = 2'd3;
  localparam logic [15:0] BUBBLE   = 16'h0800;

  logic [1:0]  state, state_n;
  logic [15:0] pc, pc_n, req_addr;
  logic [1:0]  bht [BHT_ENTRIES];

  logic        hb_valid, hb_taken, hb_err;
  logic [15:0] hb_instr, hb_pc;

  logic        is_branch, is_halt, pred_taken;
  logic [15:0] pc_plus2, target, next_pc;
  logic        ld_fetch, ld_hb, ld_bub, cap_hb, clr_hb;

  logic unused_resolve;
  assign unused_resolve = ^{resolve_pc[15:IDX_BITS+1], resolve_pc[0]};

  assign valid      = ~NOP_mech;
  assign is_branch  = (imem_data[15:13] == 3'b011);
  assign is_halt    = (imem_data[15:11] == 5'b00000);
  assign pred_taken = is_branch & bht[pc[IDX_BITS:1]][1];
  assign pc_plus2   = pc + 16'd2;
  assign target     = pc_plus2 + {{8{imem_data[7]}}, imem_data[7:0]};
  assign next_pc    = pred_taken ? target : pc_plus2;

  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = pc;
    if (!rst) begin
      case (state)
        S_RUN:            imem_rd = ~stall & ~hb_valid;
        S_WAIT, S_SQUASH: begin
          imem_rd   = 1'b1;
          imem_addr = req_addr;
        end
        default:          imem_rd = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ld_fetch = 1'b0;
    ld_hb    = 1'b0;
    ld_bub   = 1'b0;
    cap_hb   = 1'b0;
    clr_hb   = 1'b0;
    if (misprediction) begin
      pc_n    = redirect_pc;
      ld_bub  = 1'b1;
      clr_hb  = 1'b1;
      state_n = (imem_rd && !imem_done) ? S_SQUASH : S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (hb_valid) begin
            if (!stall) begin
              ld_hb  = 1'b1;
              clr_hb = 1'b1;
              if (hb_instr[15:11] == 5'b00000) state_n = S_HALT;
            end
          end else if (!stall) begin
            if (imem_done) begin
              ld_fetch = 1'b1;
              if (is_halt) state_n = S_HALT;
              else         pc_n    = next_pc;
            end else begin
              ld_bub  = 1'b1;
              state_n = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_done) begin
            state_n = S_RUN;
            if (stall) begin
              // decode still owns IF/ID: park the word and move on
              cap_hb = 1'b1;
              pc_n   = next_pc;
            end else begin
              ld_fetch = 1'b1;
              if (is_halt) state_n = S_HALT;
              else         pc_n    = next_pc;
            end
          end else if (!stall) begin
            ld_bub = 1'b1;
          end
        end
        S_SQUASH: if (imem_done) state_n = S_RUN;
        default:  if (!stall) ld_bub = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_RUN;
      pc            <= RESET_PC;
      req_addr      <= RESET_PC;
      instr         <= BUBBLE;
      PC            <= 16'h0000;
      expectedTaken <= 1'b0;
      NOP_mech      <= 1'b1;
      IDF_err       <= 1'b0;
      hb_valid      <= 1'b0;
      hb_instr      <= BUBBLE;
      hb_pc         <= 16'h0000;
      hb_taken      <= 1'b0;
      hb_err        <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (state == S_RUN && imem_rd) req_addr <= pc;
      if (ld_bub) begin
        instr         <= BUBBLE;
        PC            <= 16'h0000;
        expectedTaken <= 1'b0;
        NOP_mech      <= 1'b1;
        IDF_err       <= 1'b0;
      end else if (ld_fetch) begin
        instr         <= imem_data;
        PC            <= pc_plus2;
        expectedTaken <= pred_taken;
        NOP_mech      <= 1'b0;
        IDF_err       <= imem_err;
      end else if (ld_hb) begin
        instr         <= hb_instr;
        PC            <= hb_pc;
        expectedTaken <= hb_taken;
        NOP_mech      <= 1'b0;
        IDF_err       <= hb_err;
      end
      if (clr_hb) begin
        hb_valid <= 1'b0;
      end else if (cap_hb) begin
        hb_valid <= 1'b1;
        hb_instr <= imem_data;
        hb_pc    <= pc_plus2;
        hb_taken <= pred_taken;
        hb_err   <= imem_err;
      end
    end
  end

  // Training ignores stall; a same-cycle lookup above reads the pre-update value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (resolve_valid) begin
      if (resolve_taken) begin
        if (bht[resolve_pc[IDX_BITS:1]] != 2'b11)
          bht[resolve_pc[IDX_BITS:1]] <= bht[resolve_pc[IDX_BITS:1]] + 2'b01;
      end else begin
        if (bht[resolve_pc[IDX_BITS:1]] != 2'b00)
          bht[resolve_pc[IDX_BITS:1]] <= bht[resolve_pc[IDX_BITS:1]] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_fetch_predict.sv
// Directed-vector bench for fetch_predict: per-cycle stimulus with hand-computed
// IF/ID and fetch-request expectations, plus a reset-during-WAIT sequence.
module tb_fetch_predict;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, misprediction, resolve_valid, resolve_taken;
  logic [15:0] redirect_pc, resolve_pc;
  logic        imem_rd, imem_done, imem_err;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] instr, PC;
  logic        expectedTaken, NOP_mech, IDF_err, valid;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_predict #(.IDX_BITS(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .misprediction(misprediction),
    .redirect_pc(redirect_pc), .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_done(imem_done), .imem_err(imem_err),
    .instr(instr), .PC(PC), .expectedTaken(expectedTaken), .NOP_mech(NOP_mech),
    .IDF_err(IDF_err), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, mis;
    logic [15:0] rpc;
    logic        rv;
    logic [15:0] rspc;
    logic        rt;
    logic [15:0] data;
    logic        done, err;
    logic        e_rd;
    logic [15:0] e_addr, e_instr, e_pc;
    logic        e_tk, e_nop, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, m, input logic [15:0] rpc, input logic rv,
                              input logic [15:0] rspc, input logic rt, input logic [15:0] d,
                              input logic dn, er, input logic erd, input logic [15:0] ea, ei, ep,
                              input logic etk, enop, eerr);
    vec_t v;
    v.stall = s;  v.mis = m;  v.rpc = rpc;  v.rv = rv;  v.rspc = rspc;  v.rt = rt;
    v.data = d;   v.done = dn; v.err = er;
    v.e_rd = erd; v.e_addr = ea; v.e_instr = ei; v.e_pc = ep;
    v.e_tk = etk; v.e_nop = enop; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_bubble(input string nm, input int idx);
    chk({nm, "_instr"}, idx, instr, 16'h0800);
    chk({nm, "_pc"}, idx, PC, 16'h0000);
    chk({nm, "_nop"}, idx, {15'b0, NOP_mech}, 16'h0001);
    chk({nm, "_valid"}, idx, {15'b0, valid}, 16'h0000);
    chk({nm, "_tk"}, idx, {15'b0, expectedTaken}, 16'h0000);
    chk({nm, "_idferr"}, idx, {15'b0, IDF_err}, 16'h0000);
  endtask

  initial begin
    rst = H; stall = L; misprediction = L; redirect_pc = '0;
    resolve_valid = L; resolve_pc = '0; resolve_taken = L;
    imem_data = '0; imem_done = L; imem_err = L;

    // straight-line code with zero-latency memory, training idx of 0x0010 three times taken
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1100,H,L, H,16'h0000,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1101,H,L, H,16'h0002,16'h1100,16'h0002,L,L,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1102,H,H, H,16'h0004,16'h1101,16'h0004,L,L,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1103,H,L, H,16'h0006,16'h1102,16'h0006,L,L,H));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1104,H,L, H,16'h0008,16'h1103,16'h0008,L,L,L));
    vecs.push_back(mk(L,L,16'h0,H,16'h0010,H,16'h1105,H,L, H,16'h000A,16'h1104,16'h000A,L,L,L));
    vecs.push_back(mk(L,L,16'h0,H,16'h0010,H,16'h1106,H,L, H,16'h000C,16'h1105,16'h000C,L,L,L));
    vecs.push_back(mk(L,L,16'h0,H,16'h0010,H,16'h1107,H,L, H,16'h000E,16'h1106,16'h000E,L,L,L));
    // BEQZ imm 4 at 0x0010 with counter saturated at 11 -> taken to 0x0016
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h6004,H,L, H,16'h0010,16'h1107,16'h0010,L,L,L));
    vecs.push_back(mk(L,L,16'h0,H,16'h0010,L,16'h1108,H,L, H,16'h0016,16'h6004,16'h0012,H,L,L));
    vecs.push_back(mk(L,L,16'h0,H,16'h0010,L,16'h1109,H,L, H,16'h0018,16'h1108,16'h0018,L,L,L));
    // redirect back to 0x0010; counter now 01 -> not taken, next 0x0012
    vecs.push_back(mk(L,H,16'h0010,L,16'h0,L,16'h110A,H,L, H,16'h001A,16'h1109,16'h001A,L,L,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h6004,H,L, H,16'h0010,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,L,L, H,16'h0012,16'h6004,16'h0012,L,L,L));
    // word returns during stall: held, then presented with no new read
    vecs.push_back(mk(H,L,16'h0,L,16'h0,L,16'h0000,L,L, H,16'h0012,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(H,L,16'h0,L,16'h0,L,16'h1234,H,L, H,16'h0012,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(H,L,16'h0,L,16'h0,L,16'h0000,L,L, L,16'h0014,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,L,L, L,16'h0014,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1300,H,L, H,16'h0014,16'h1234,16'h0014,L,L,L));
    // misprediction while WAIT, stale word two cycles later is dropped
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,L,L, H,16'h0016,16'h1300,16'h0016,L,L,L));
    vecs.push_back(mk(L,H,16'h0040,L,16'h0,L,16'h0000,L,L, H,16'h0016,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,L,L, H,16'h0016,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1EEE,H,L, H,16'h0016,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,L,L, H,16'h0040,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1400,H,L, H,16'h0040,16'h0800,16'h0000,L,H,L));
    // HALT fetched at 0x0042: no reads until misprediction
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,H,L, H,16'h0042,16'h1400,16'h0042,L,L,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,L,L, L,16'h0042,16'h0000,16'h0044,L,L,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,L,L, L,16'h0042,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(H,L,16'h0,L,16'h0,L,16'h0000,L,L, L,16'h0042,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,H,16'h0080,L,16'h0,L,16'h0000,L,L, L,16'h0042,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1500,H,L, H,16'h0080,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,L,L, H,16'h0082,16'h1500,16'h0082,L,L,L));
    // pc wrap at 0xFFFE
    vecs.push_back(mk(L,H,16'hFFFE,L,16'h0,L,16'h1600,H,L, H,16'h0082,16'h0800,16'h0000,L,H,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h1601,H,L, H,16'hFFFE,16'h0800,16'h0000,L,H,L));
    // idx 1 from reset 01, one taken -> 10; same-cycle not-taken update must not affect lookup
    vecs.push_back(mk(L,L,16'h0,H,16'h0002,H,16'h1602,H,L, H,16'h0000,16'h1601,16'h0000,L,L,L));
    vecs.push_back(mk(L,L,16'h0,H,16'h0002,L,16'h6002,H,L, H,16'h0002,16'h1602,16'h0002,L,L,L));
    vecs.push_back(mk(L,L,16'h0,L,16'h0,L,16'h0000,L,L, H,16'h0006,16'h6002,16'h0004,H,L,L));

    @(negedge clk); #1;
    chk("rst_rd", -1, {15'b0, imem_rd}, 16'h0000);
    chk_bubble("rst", -1);
    @(negedge clk); rst = L; #1;
    chk("rel_rd", -1, {15'b0, imem_rd}, 16'h0001);
    @(negedge clk); #1;
    chk("wait_rd", -2, {15'b0, imem_rd}, 16'h0001);
    chk("wait_addr", -2, imem_addr, 16'h0000);
    #2 rst = H; #1;
    chk("midrst_rd", -3, {15'b0, imem_rd}, 16'h0000);
    chk_bubble("midrst", -3);
    @(negedge clk); rst = L; #1;
    chk("first_rd", -4, {15'b0, imem_rd}, 16'h0001);
    chk("first_addr", -4, imem_addr, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; misprediction = vecs[i].mis; redirect_pc = vecs[i].rpc;
      resolve_valid = vecs[i].rv; resolve_pc = vecs[i].rspc; resolve_taken = vecs[i].rt;
      imem_data = vecs[i].data; imem_done = vecs[i].done; imem_err = vecs[i].err;
      #1;
      chk("imem_rd", i, {15'b0, imem_rd}, {15'b0, vecs[i].e_rd});
      chk("imem_addr", i, imem_addr, vecs[i].e_addr);
      chk("instr", i, instr, vecs[i].e_instr);
      chk("PC", i, PC, vecs[i].e_pc);
      chk("expectedTaken", i, {15'b0, expectedTaken}, {15'b0, vecs[i].e_tk});
      chk("NOP_mech", i, {15'b0, NOP_mech}, {15'b0, vecs[i].e_nop});
      chk("valid", i, {15'b0, valid}, {15'b0, ~vecs[i].e_nop});
      chk("IDF_err", i, {15'b0, IDF_err}, {15'b0, vecs[i].e_err});
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
